square_move_ctrl: RTL

- Sequences the on-screen square position for the VGA square renderer from PS/2 scan-code bytes delivered by the keyboard receiver.
- Decodes set-2 make, break and extended prefixes (E0, F0) into four held-arrow flags, then steps the square position at a programmable repeat rate with edge clamping.
- Sits between the keyboard receiver and the VGA square and LFSR counter blocks; its "moving" flag replaces the ad-hoc toggle logic at top level.

---
 rtl/square_move_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/square_move_ctrl.sv
// PS/2 set-2 arrow-key decoder driving the square position with repeat-rate stepping.
// Define SQ_WRAP_EN to wrap the position at the borders instead of clamping it.
module square_move_ctrl #(
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned SQ_SIZE        = 32,
    parameter int unsigned STEP           = 4,
    parameter int unsigned REPEAT_DIV     = 500000,
    parameter int unsigned PREFIX_TIMEOUT = 1000000,
    parameter int unsigned X_INIT         = 304,
    parameter int unsigned Y_INIT         = 224
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] code,
    input  logic       code_valid,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [3:0] held,
    output logic       moving,
    output logic       edge_hit
);

    localparam int unsigned REP_W = $clog2(REPEAT_DIV);
    localparam int unsigned TMO_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(PREFIX_TIMEOUT - 1);
    localparam logic signed [10:0] X_LIM  = 11'(H_ACTIVE - SQ_SIZE);
    localparam logic signed [10:0] Y_LIM  = 11'(V_ACTIVE - SQ_SIZE);
    localparam logic signed [10:0] STEP_S = 11'(STEP);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

    state_t           state, state_next;
    logic             do_make, do_break;
    logic [3:0]       key_mask, held_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic [REP_W-1:0] rep_cnt, rep_next;
    logic signed [1:0] dx, dy, dx_r, dy_r;
    logic             any_dir, start, fire;
    logic [10:0]      sx, sy;

    // Returns {hit, new_pos}; a zero direction leaves the position untouched.
    function automatic logic [10:0] step_axis(input logic [9:0] pos,
                                              input logic signed [1:0] dir,
                                              input logic signed [10:0] lim);
        logic signed [10:0] p, s;
        logic hit;
        p   = signed'({1'b0, pos});
        s   = p;
        hit = 1'b0;
        if (dir > 2'sd0)      s = p + STEP_S;
        else if (dir < 2'sd0) s = p - STEP_S;
`ifdef SQ_WRAP_EN
        if (s < 11'sd0) begin
            s   = s + lim + 11'sd1;
            hit = 1'b1;
        end else if (s > lim) begin
            s   = s - (lim + 11'sd1);
            hit = 1'b1;
        end
`else
        if ((dir > 2'sd0 && p == lim) || (dir < 2'sd0 && p == 11'sd0)) hit = 1'b1;
        if (s < 11'sd0) begin
            s   = 11'sd0;
            hit = 1'b1;
        end else if (s > lim) begin
            s   = lim;
            hit = 1'b1;
        end
`endif
        return {hit, s[9:0]};
    endfunction

    always_comb begin
        key_mask = 4'b0000;
        case (code)
            8'h6B:   key_mask = 4'b0001;
            8'h74:   key_mask = 4'b0010;
            8'h72:   key_mask = 4'b0100;
            8'h75:   key_mask = 4'b1000;
            default: key_mask = 4'b0000;
        endcase
    end

    always_comb begin
        state_next = state;
        do_make    = 1'b0;
        do_break   = 1'b0;
        if (code_valid) begin
            case (state)
                IDLE: begin
                    if (code == 8'hE0)      state_next = EXT;
                    else if (code == 8'hF0) state_next = BRK;
                    else                    do_make = 1'b1;
                end
                EXT: begin
                    if (code == 8'hF0)      state_next = EXTBRK;
                    else if (code == 8'hE0) state_next = EXT;
                    else begin
                        do_make    = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK, EXTBRK: begin
                    do_break   = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TMO_MAX) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                         tmo_cnt <= '0;
        else if (code_valid || state == IDLE || tmo_cnt == TMO_MAX) tmo_cnt <= '0;
        else                                               tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_comb begin
        held_next = held;
        if (do_make)       held_next = held | key_mask;
        else if (do_break) held_next = held & ~key_mask;
    end

    always_comb begin
        dx = 2'sd0;
        dy = 2'sd0;
        if (held[1] && !held[0])      dx = 2'sd1;
        else if (held[0] && !held[1]) dx = -2'sd1;
        if (held[2] && !held[3])      dy = 2'sd1;
        else if (held[3] && !held[2]) dy = -2'sd1;
    end

    // An axis gaining a direction steps at once and restarts the repeat interval.
    always_comb begin
        any_dir  = (dx != 2'sd0) || (dy != 2'sd0);
        start    = (dx != 2'sd0 && dx_r == 2'sd0) || (dy != 2'sd0 && dy_r == 2'sd0);
        fire     = start || (any_dir && rep_cnt == REP_MAX);
        rep_next = '0;
        if (!start && any_dir && rep_cnt != REP_MAX) rep_next = rep_cnt + 1'b1;
        sx = step_axis(pos_x, dx, X_LIM);
        sy = step_axis(pos_y, dy, Y_LIM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held     <= '0;
            dx_r     <= '0;
            dy_r     <= '0;
            moving   <= 1'b0;
            rep_cnt  <= '0;
            pos_x    <= 10'(X_INIT);
            pos_y    <= 10'(Y_INIT);
            edge_hit <= 1'b0;
        end else begin
            held     <= held_next;
            dx_r     <= dx;
            dy_r     <= dy;
            moving   <= any_dir;
            rep_cnt  <= rep_next;
            edge_hit <= 1'b0;
            if (fire) begin
                pos_x    <= sx[9:0];
                pos_y    <= sy[9:0];
                edge_hit <= sx[10] | sy[10];
            end
        end
    end

endmodule
